// File: rtl/bar_display_pipe.sv
// Pipelined spectrum bar renderer: latches bar values per frame, computes heights
// and peak-hold markers one bar per cycle, and renders pixels through a 2-stage pipe.
module bar_display_pipe #(
  parameter int NUM_BARS    = 16,
  parameter int BAR_W       = 40,
  parameter int SPACING     = 1,
  parameter int VALUE_W     = 16,
  parameter int SCREEN_H    = 480,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_PX    = 4,
  parameter int PEAK_THICK  = 2
) (
  input  logic               fsm_clk,
  input  logic               reset_n,
  input  logic [VALUE_W-1:0] bars [NUM_BARS],
  input  logic               frame_start,
  input  logic               mode,
  input  logic               pixel_valid,
  input  logic [9:0]         x_coord,
  input  logic [9:0]         y_coord,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               rgb_valid,
  output logic               busy,
  output logic               frame_drop
);

  localparam int HW    = $clog2(SCREEN_H + 1);
  localparam int PW    = VALUE_W + 1 + HW;
  localparam int IDXW  = $clog2(NUM_BARS);
  localparam int HOLDW = $clog2(HOLD_FRAMES + 1);
  localparam int COLW  = $clog2(BAR_W + 1);

  localparam logic [10:0]      XMAX  = 11'(NUM_BARS * BAR_W);
  localparam logic [10:0]      YMAX  = 11'(SCREEN_H);
  localparam logic [10:0]      Y1    = 11'(SCREEN_H / 3);
  localparam logic [10:0]      Y2    = 11'((2 * SCREEN_H) / 3);
  localparam logic [10:0]      THICK = 11'(PEAK_THICK);
  localparam logic [COLW-1:0]  SP    = COLW'(SPACING);
  localparam logic [HW-1:0]    DEC   = HW'(DECAY_PX);
  localparam logic [HOLDW-1:0] HOLDV = HOLDW'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  state_t             r_state;
  logic [IDXW-1:0]    r_cnt;
  logic               r_busy;
  logic               r_frameDrop;
  logic [VALUE_W-1:0] r_shadow   [NUM_BARS];
  logic [HW-1:0]      r_workH    [NUM_BARS];
  logic [HW-1:0]      r_dispH    [NUM_BARS];
  logic [HW-1:0]      r_peak     [NUM_BARS];
  logic [HW-1:0]      r_dispPeak [NUM_BARS];
  logic [HOLDW-1:0]   r_hold     [NUM_BARS];

  logic [PW-1:0]    w_prod;
  logic [HW-1:0]    w_h;
  logic [HW-1:0]    w_decayed;
  logic [HW-1:0]    w_newPeak;
  logic [HOLDW-1:0] w_newHold;

  // The single shared multiplier serves whichever bar the counter points at.
  assign w_prod = (PW'(r_shadow[r_cnt]) + PW'(1)) * PW'(SCREEN_H);
  assign w_h    = HW'(w_prod >> VALUE_W);

  always_comb begin
    w_decayed = (r_peak[r_cnt] > DEC) ? (r_peak[r_cnt] - DEC) : '0;
    w_newPeak = r_peak[r_cnt];
    w_newHold = r_hold[r_cnt];
    if (w_h >= r_peak[r_cnt]) begin
      w_newPeak = w_h;
      w_newHold = HOLDV;
    end else if (r_hold[r_cnt] != '0) begin
      w_newHold = r_hold[r_cnt] - HOLDW'(1);
    end else begin
      w_newPeak = (w_h > w_decayed) ? w_h : w_decayed;
    end
  end

  always_ff @(posedge fsm_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_frameDrop <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        r_shadow[i]   <= '0;
        r_workH[i]    <= '0;
        r_dispH[i]    <= '0;
        r_peak[i]     <= '0;
        r_dispPeak[i] <= '0;
        r_hold[i]     <= '0;
      end
    end else begin
      r_frameDrop <= frame_start && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_shadow <= bars;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= UPDATE;
          end
        end
        UPDATE: begin
          r_workH[r_cnt] <= w_h;
          r_peak[r_cnt]  <= w_newPeak;
          r_hold[r_cnt]  <= w_newHold;
          if (r_cnt == IDXW'(NUM_BARS - 1)) begin
            r_state <= COMMIT;
          end else begin
            r_cnt <= r_cnt + IDXW'(1);
          end
        end
        COMMIT: begin
          r_dispH    <= r_workH;
          r_dispPeak <= r_peak;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [IDXW-1:0] w_idx;
  logic [COLW-1:0] w_col;
  logic            w_blank;
  logic            r_s1Valid;
  logic            r_s1Blank;
  logic            r_s1Mode;
  logic [9:0]      r_s1Y;
  logic [IDXW-1:0] r_s1Idx;

  assign w_idx   = IDXW'(x_coord / 10'(BAR_W));
  assign w_col   = COLW'(x_coord % 10'(BAR_W));
  assign w_blank = ({1'b0, x_coord} >= XMAX) || ({1'b0, y_coord} >= YMAX) || (w_col < SP);

  always_ff @(posedge fsm_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1Blank <= 1'b1;
      r_s1Mode  <= 1'b0;
      r_s1Y     <= '0;
      r_s1Idx   <= '0;
    end else begin
      r_s1Valid <= pixel_valid;
      r_s1Blank <= w_blank;
      r_s1Mode  <= mode;
      r_s1Y     <= y_coord;
      r_s1Idx   <= w_blank ? '0 : w_idx;
    end
  end

  logic [10:0] w_y;
  logic [10:0] w_bodyTop;
  logic [10:0] w_pkTop;
  logic [HW-1:0] w_h2;
  logic [HW-1:0] w_pk2;
  logic [11:0] w_rgb;
  logic [11:0] r_rgb;
  logic        r_rgbValid;

  assign w_h2      = r_dispH[r_s1Idx];
  assign w_pk2     = r_dispPeak[r_s1Idx];
  assign w_y       = {1'b0, r_s1Y};
  assign w_bodyTop = YMAX - 11'(w_h2);
  assign w_pkTop   = YMAX - 11'(w_pk2);

  // Peak marker outranks the bar body so it stays visible inside a tall bar.
  always_comb begin
    w_rgb = 12'h000;
    if (r_s1Valid && !r_s1Blank) begin
      if ((w_pk2 != '0) && (w_y >= w_pkTop) && (w_y < w_pkTop + THICK)) begin
        w_rgb = 12'hF00;
      end else if ((w_h2 != '0) && (w_y >= w_bodyTop)) begin
        if (!r_s1Mode)      w_rgb = 12'hFFF;
        else if (w_y < Y1)  w_rgb = 12'hF00;
        else if (w_y < Y2)  w_rgb = 12'hFF0;
        else                w_rgb = 12'h0F0;
      end
    end
  end

  always_ff @(posedge fsm_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb      <= '0;
      r_rgbValid <= 1'b0;
    end else begin
      r_rgb      <= w_rgb;
      r_rgbValid <= r_s1Valid;
    end
  end

  assign red        = r_rgb[11:8];
  assign green      = r_rgb[7:4];
  assign blue       = r_rgb[3:0];
  assign rgb_valid  = r_rgbValid;
  assign busy       = r_busy;
  assign frame_drop = r_frameDrop;

endmodule

// File: tb/tb_bar_display_pipe.sv
// Scoreboard bench for bar_display_pipe: directed frames and pixels, expected
// colours queued at issue time and compared by an independent monitor.
module tb_bar_display_pipe;

  logic        fsm_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bars [16];
  logic        frame_start = 1'b0;
  logic        mode = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [9:0]  x_coord = '0;
  logic [9:0]  y_coord = '0;
  logic [3:0]  red, green, blue;
  logic        rgb_valid, busy, frame_drop;
  logic [11:0] rgb;

  typedef struct {
    logic [11:0] rgb;
    int          x;
    int          y;
  } exp_t;

  exp_t expQ [$];
  bit   sbOn = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  bar_display_pipe dut (
    .fsm_clk     (fsm_clk),
    .reset_n     (reset_n),
    .bars        (bars),
    .frame_start (frame_start),
    .mode        (mode),
    .pixel_valid (pixel_valid),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .rgb_valid   (rgb_valid),
    .busy        (busy),
    .frame_drop  (frame_drop)
  );

  assign rgb = {red, green, blue};

  always #5 fsm_clk = ~fsm_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every valid pixel leaving the DUT is matched against the oldest expectation.
  always @(negedge fsm_clk) begin
    if (sbOn && reset_n && rgb_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rgb_valid", int'(rgb_valid), 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("pixel(%0d,%0d)", e.x, e.y), int'(rgb), int'(e.rgb));
      end
    end
  end

  task automatic issuePixel(input int x, input int y, input logic [11:0] expRgb);
    exp_t e;
    pixel_valid = 1'b1;
    x_coord = 10'(x);
    y_coord = 10'(y);
    e.rgb = expRgb;
    e.x = x;
    e.y = y;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int x, input int y, input logic [11:0] expRgb);
    issuePixel(x, y, expRgb);
    @(negedge fsm_clk);
    pixel_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge fsm_clk);
  endtask

  task automatic doFrame(input string name);
    int n;
    n = 0;
    frame_start = 1'b1;
    @(negedge fsm_clk);
    frame_start = 1'b0;
    while (busy && n < 100) begin
      n++;
      @(negedge fsm_clk);
    end
    checkOutput({name, "_busy_len"}, n, 17);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCnt;
    int dropCnt;
    for (int i = 0; i < 16; i++) bars[i] = 16'h0000;

    repeat (3) @(negedge fsm_clk);
    checkOutput("reset_rgb", int'(rgb), 0);
    checkOutput("reset_rgb_valid", int'(rgb_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_frame_drop", int'(frame_drop), 0);
    reset_n = 1'b1;
    @(negedge fsm_clk);
    sbOn = 1'b1;

    // Half-scale bar 0: height 240, peak marker on rows 240-241
    bars[0] = 16'h7FFF;
    doFrame("frameA");
    applyStimulus(5, 240, 12'hF00);
    applyStimulus(5, 242, 12'hFFF);
    applyStimulus(5, 239, 12'h000);
    applyStimulus(0, 300, 12'h000);
    applyStimulus(40, 300, 12'h000);
    applyStimulus(45, 479, 12'h000);
    applyStimulus(39, 479, 12'hFFF);
    applyStimulus(5, 480, 12'h000);
    applyStimulus(640, 300, 12'h000);
    applyStimulus(639, 479, 12'h000);
    drain();

    // Gradient mode on a full-scale bar 2
    bars[2] = 16'hFFFF;
    doFrame("frameB");
    mode = 1'b1;
    applyStimulus(85, 10, 12'hF00);
    applyStimulus(85, 400, 12'h0F0);
    applyStimulus(5, 300, 12'hFF0);
    applyStimulus(5, 240, 12'hF00);
    issuePixel(85, 200, 12'hFF0);
    @(negedge fsm_clk);
    pixel_valid = 1'b0;
    mode = 1'b0;
    applyStimulus(85, 200, 12'hFFF);
    applyStimulus(85, 1, 12'hF00);
    applyStimulus(85, 2, 12'hFFF);
    drain();

    // Peak hold for 30 frames then decay by 4 rows per frame
    bars[2] = 16'h0000;
    bars[0] = 16'hFFFF;
    doFrame("frameC0");
    applyStimulus(5, 0, 12'hF00);
    applyStimulus(5, 2, 12'hFFF);
    drain();
    bars[0] = 16'h0000;
    for (int k = 1; k <= 32; k++) begin
      doFrame($sformatf("hold%0d", k));
      if (k == 1 || k == 30) begin
        applyStimulus(5, 0, 12'hF00);
        applyStimulus(5, 1, 12'hF00);
        applyStimulus(5, 2, 12'h000);
        drain();
      end else if (k == 31) begin
        applyStimulus(5, 0, 12'h000);
        applyStimulus(5, 3, 12'h000);
        applyStimulus(5, 4, 12'hF00);
        applyStimulus(5, 5, 12'hF00);
        applyStimulus(5, 6, 12'h000);
        drain();
      end else if (k == 32) begin
        applyStimulus(5, 4, 12'h000);
        applyStimulus(5, 8, 12'hF00);
        applyStimulus(5, 9, 12'hF00);
        drain();
      end
    end

    // Dropped second frame_start and tear-free switch-over at commit
    bars[0] = 16'h7FFF;
    busyCnt = 0;
    dropCnt = 0;
    frame_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge fsm_clk);
      if (busy) busyCnt++;
      if (frame_drop) dropCnt++;
      case (k)
        1: frame_start = 1'b0;
        5: frame_start = 1'b1;
        6: begin
          frame_start = 1'b0;
          checkOutput("frame_drop_pulse", int'(frame_drop), 1);
        end
        16: issuePixel(5, 300, 12'h000);
        17: pixel_valid = 1'b0;
        18: issuePixel(5, 300, 12'hFFF);
        19: pixel_valid = 1'b0;
        default: ;
      endcase
    end
    checkOutput("drop_busy_len", busyCnt, 17);
    checkOutput("drop_pulse_count", dropCnt, 1);
    applyStimulus(5, 12, 12'hF00);
    applyStimulus(5, 13, 12'hF00);
    applyStimulus(5, 14, 12'h000);
    drain();

    // pixel_valid toggling 1,0,1 must reappear two cycles later
    issuePixel(640, 300, 12'h000);
    @(negedge fsm_clk);
    pixel_valid = 1'b0;
    @(negedge fsm_clk);
    checkOutput("toggle_valid_0", int'(rgb_valid), 1);
    issuePixel(5, 300, 12'hFFF);
    @(negedge fsm_clk);
    checkOutput("toggle_valid_1", int'(rgb_valid), 0);
    pixel_valid = 1'b0;
    @(negedge fsm_clk);
    checkOutput("toggle_valid_2", int'(rgb_valid), 1);
    drain();

    // Asynchronous reset in the middle of an update
    sbOn = 1'b0;
    pixel_valid = 1'b1;
    x_coord = 10'd5;
    y_coord = 10'd300;
    frame_start = 1'b1;
    @(negedge fsm_clk);
    frame_start = 1'b0;
    repeat (4) @(negedge fsm_clk);
    checkOutput("pre_reset_busy", int'(busy), 1);
    checkOutput("pre_reset_rgb_valid", int'(rgb_valid), 1);
    checkOutput("pre_reset_rgb", int'(rgb), 12'hFFF);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_rgb", int'(rgb), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_rgb_valid", int'(rgb_valid), 0);
    pixel_valid = 1'b0;
    @(negedge fsm_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge fsm_clk);
    expQ.delete();
    sbOn = 1'b1;
    applyStimulus(5, 300, 12'h000);
    applyStimulus(5, 240, 12'h000);
    applyStimulus(5, 12, 12'h000);
    applyStimulus(85, 10, 12'h000);
    drain();
    checkOutput("post_reset_busy", int'(busy), 0);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
